// File: rtl/ycr1_wbb_sync_buf_if.sv
// ycr1_wbb_sync_buf_if: Wishbone burst bus (request + response) with master/slave modports.
interface ycr1_wbb_sync_buf_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BW = DW/8,
  parameter int BL = 10
);
  logic          cyc, stb, we, ack, lack, err;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w, dat_r;
  logic [BW-1:0] sel;
  logic [BL-1:0] bl;
  modport master (output cyc, stb, we, adr, dat_w, sel, bl, input dat_r, ack, lack, err);
  modport slave (input cyc, stb, we, adr, dat_w, sel, bl, output dat_r, ack, lack, err);
endinterface

// File: rtl/ycr1_wbb_sync_buf.sv
// ycr1_wbb_sync_buf: single-clock Wishbone burst buffer, posted writes and buffered burst reads.
module ycr1_wbb_sync_buf #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int BW     = DW/8,
  parameter int BL     = 10,
  parameter int CDP    = 4,
  parameter int RDP    = 8,
  parameter int TO_CYC = 1024
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_n,
  ycr1_wbb_sync_buf_if.slave         wbm,
  ycr1_wbb_sync_buf_if.master        wbs,
  output logic                       bus_err_o
);
  localparam int CA = $clog2(CDP);
  localparam int RA = $clog2(RDP);
  typedef struct packed {
    logic [AW-1:0] adr;
    logic          we;
    logic [DW-1:0] dat;
    logic [BW-1:0] sel;
    logic [BL-1:0] bl;
  } cmd_t;
  typedef struct packed {
    logic          err;
    logic          lack;
    logic [DW-1:0] dat;
  } rsp_t;
  cmd_t cmd_mem [CDP];
  rsp_t rsp_mem [RDP];
  cmd_t ch;
  rsp_t rh, rsp_din;
  logic [CA:0] cwp_q, crp_q;
  logic [RA:0] rwp_q, rrp_q, rcnt;
  logic [BL-1:0] bcnt_q, bcnt_d, bcnt;
  logic pend_rd_q, pend_rd_d, first_q, first_d, blank_q, blank_d, bus_err_q, bus_err_d;
  logic cmd_empty, cmd_full, rsp_empty, rsp_thr;
  logic mw_acc, mr_push, cmd_push, cmd_pop, rsp_push, rsp_pop;
  logic s_ack, s_err, s_lack, to_hit, err_rsp;
  assign cmd_empty = cwp_q == crp_q;
  assign cmd_full  = cwp_q[CA] != crp_q[CA] && cwp_q[CA-1:0] == crp_q[CA-1:0];
  assign rsp_empty = rwp_q == rrp_q;
  assign rcnt      = rwp_q - rrp_q;
  assign ch        = cmd_mem[crp_q[CA-1:0]];
  assign rh        = rsp_mem[rrp_q[RA-1:0]];
  assign rsp_thr   = !ch.we && rcnt >= (RA+1)'(RDP-1);
  assign mw_acc    = wbm.cyc && wbm.stb && wbm.we && !pend_rd_q && !cmd_full;
  assign mr_push   = wbm.cyc && wbm.stb && !wbm.we && !pend_rd_q && !cmd_full;
  assign cmd_push  = mw_acc || mr_push;
  assign rsp_pop   = wbm.cyc && wbm.stb && !wbm.we && !rsp_empty;
  assign bcnt      = first_q ? wbm.bl - BL'(1) : bcnt_q;
  assign wbm.ack   = mw_acc || rsp_pop;
  assign wbm.lack  = mw_acc ? bcnt == '0 : rsp_pop && rh.lack;
  assign wbm.err   = rsp_pop && rh.err;
  assign wbm.dat_r = rsp_pop ? rh.dat : '0;
  assign wbs.cyc   = !cmd_empty && !blank_q;
  assign wbs.stb   = wbs.cyc && !rsp_thr;
  assign wbs.we    = !cmd_empty && ch.we;
  assign wbs.adr   = cmd_empty ? '0 : ch.adr;
  assign wbs.dat_w = cmd_empty ? '0 : ch.dat;
  assign wbs.sel   = cmd_empty ? '0 : ch.sel;
  assign wbs.bl    = cmd_empty ? '0 : ch.bl;
  assign s_ack     = wbs.stb && wbs.ack;
  assign s_err     = wbs.stb && wbs.err;
  assign s_lack    = wbs.stb && wbs.lack;
  assign err_rsp   = s_err || to_hit;
  assign cmd_pop   = (ch.we ? s_ack || s_err : s_lack || s_err) || to_hit;
  assign rsp_push  = !ch.we && (s_ack || s_lack || err_rsp);
  assign rsp_din   = {err_rsp, s_lack || err_rsp, wbs.dat_r & {DW{!err_rsp}}};
  assign bus_err_o = bus_err_q;
`ifdef YCR1_WBB_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC) + 1;
  logic [TW-1:0] to_q, to_d;
  assign to_hit = wbs.stb && !wbs.ack && !wbs.err && !wbs.lack && to_q == TW'(TO_CYC - 1);
  assign to_d   = (cmd_empty || s_ack || s_err || s_lack || to_hit) ? '0 : wbs.stb ? to_q + TW'(1) : to_q;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n)
    if (!wb_rst_n) to_q <= '0;
    else to_q <= to_d;
`else
  assign to_hit = 1'b0;
`endif
  always_comb begin
    pend_rd_d = mr_push ? 1'b1 : (rsp_pop && rh.lack) ? 1'b0 : pend_rd_q;
    first_d   = mw_acc ? bcnt == '0 : first_q;
    bcnt_d    = mw_acc ? bcnt - BL'(1) : bcnt_q;
    blank_d   = s_lack || err_rsp;
    bus_err_d = (ch.we && s_err) || to_hit;
  end
  always_ff @(posedge wb_clk_i) begin
    if (cmd_push) cmd_mem[cwp_q[CA-1:0]] <= {wbm.adr, wbm.we, wbm.dat_w, wbm.sel, wbm.bl};
    if (rsp_push) rsp_mem[rwp_q[RA-1:0]] <= rsp_din;
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n)
    if (!wb_rst_n) begin
      cwp_q     <= '0;
      crp_q     <= '0;
      rwp_q     <= '0;
      rrp_q     <= '0;
      pend_rd_q <= 1'b0;
      first_q   <= 1'b1;
      bcnt_q    <= '0;
      blank_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      cwp_q     <= cwp_q + (CA+1)'(cmd_push);
      crp_q     <= crp_q + (CA+1)'(cmd_pop);
      rwp_q     <= rwp_q + (RA+1)'(rsp_push);
      rrp_q     <= rrp_q + (RA+1)'(rsp_pop);
      pend_rd_q <= pend_rd_d;
      first_q   <= first_d;
      bcnt_q    <= bcnt_d;
      blank_q   <= blank_d;
      bus_err_q <= bus_err_d;
    end
endmodule

// File: tb/tb_ycr1_wbb_sync_buf.sv
// tb_ycr1_wbb_sync_buf: vector and directed-sequence bench for the Wishbone burst buffer.
module tb_ycr1_wbb_sync_buf;
  logic clk, rst_n, bus_err;
  int nvec, nerr, k, got, n;
  ycr1_wbb_sync_buf_if #(.AW(32), .DW(32), .BL(10)) m_if ();
  ycr1_wbb_sync_buf_if #(.AW(32), .DW(32), .BL(10)) s_if ();
  ycr1_wbb_sync_buf #(.TO_CYC(16)) dut (.wb_clk_i(clk), .wb_rst_n(rst_n), .wbm(m_if), .wbs(s_if), .bus_err_o(bus_err));
  typedef struct {
    string         nm;
    logic          mc, mw, sa, sl, se;
    logic [31:0]   adr, dat, sd;
    logic [9:0]    bl;
    logic [102:0]  exp;
  } vec_t;
  vec_t v [17];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  function automatic logic [102:0] outs();
    return {m_if.ack, m_if.lack, m_if.err, m_if.dat_r, s_if.cyc, s_if.stb, s_if.we, s_if.adr, s_if.dat_w, bus_err};
  endfunction
  function automatic vec_t mk(string nm, logic mc, mw, logic [31:0] adr, dat, logic [9:0] bl,
                              logic sa, sl, se, logic [31:0] sd, logic [2:0] em, logic [31:0] ed,
                              logic [2:0] es, logic [31:0] eadr, esd, logic ebe);
    vec_t r;
    r.nm = nm; r.mc = mc; r.mw = mw; r.adr = adr; r.dat = dat; r.bl = bl;
    r.sa = sa; r.sl = sl; r.se = se; r.sd = sd;
    r.exp = {em, ed, es, eadr, esd, ebe};
    return r;
  endfunction
  task automatic drive(input logic mc, mw, input logic [31:0] adr, dat, input logic [9:0] bl,
                       input logic sa, sl, se, input logic [31:0] sd);
    m_if.cyc = mc; m_if.stb = mc; m_if.we = mw; m_if.adr = adr; m_if.dat_w = dat;
    m_if.sel = 4'hF; m_if.bl = bl;
    s_if.ack = sa; s_if.lack = sl; s_if.err = se; s_if.dat_r = sd;
  endtask
  task automatic chk(input string nm, input logic [102:0] act, exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic step(input logic mc, mw, input logic [31:0] adr, dat, input logic [9:0] bl,
                      input logic sa, sl, se, input logic [31:0] sd);
    @(posedge clk); #1;
    drive(mc, mw, adr, dat, bl, sa, sl, se, sd);
    @(negedge clk);
  endtask
  initial begin
    nvec = 0; nerr = 0;
    v[0]  = mk("rst_idle",      0,0,32'h0,  32'h0,        10'd0, 0,0,0,32'h0,      3'b000,32'h0,        3'b000,32'h0,  32'h0,        0);
    v[1]  = mk("wr_single_ack", 1,1,32'h100,32'hA5A5_0001,10'd1, 0,0,0,32'h0,      3'b110,32'h0,        3'b000,32'h0,  32'h0,        0);
    v[2]  = mk("wr_single_slv", 0,0,32'h0,  32'h0,        10'd0, 1,1,0,32'h0,      3'b000,32'h0,        3'b111,32'h100,32'hA5A5_0001,0);
    v[3]  = mk("wr_single_done",0,0,32'h0,  32'h0,        10'd0, 0,0,0,32'h0,      3'b000,32'h0,        3'b000,32'h0,  32'h0,        0);
    v[4]  = mk("rd_push",       1,0,32'h200,32'h0,        10'd2, 0,0,0,32'h0,      3'b000,32'h0,        3'b000,32'h0,  32'h0,        0);
    v[5]  = mk("rd_beat0",      1,0,32'h200,32'h0,        10'd2, 1,0,0,32'h1111_1111,3'b000,32'h0,      3'b110,32'h200,32'h0,        0);
    v[6]  = mk("rd_beat1",      1,0,32'h200,32'h0,        10'd2, 1,1,0,32'h2222_2222,3'b100,32'h1111_1111,3'b110,32'h200,32'h0,      0);
    v[7]  = mk("rd_last",       1,0,32'h200,32'h0,        10'd2, 0,0,0,32'h0,      3'b110,32'h2222_2222,3'b000,32'h0,  32'h0,        0);
    v[8]  = mk("rd_idle",       0,0,32'h0,  32'h0,        10'd0, 0,0,0,32'h0,      3'b000,32'h0,        3'b000,32'h0,  32'h0,        0);
    v[9]  = mk("wrerr_ack",     1,1,32'h300,32'hDEAD_0003,10'd1, 0,0,0,32'h0,      3'b110,32'h0,        3'b000,32'h0,  32'h0,        0);
    v[10] = mk("wrerr_slv",     0,0,32'h0,  32'h0,        10'd0, 0,0,1,32'h0,      3'b000,32'h0,        3'b111,32'h300,32'hDEAD_0003,0);
    v[11] = mk("wrerr_pulse",   0,0,32'h0,  32'h0,        10'd0, 0,0,0,32'h0,      3'b000,32'h0,        3'b000,32'h0,  32'h0,        1);
    v[12] = mk("wrerr_clr",     0,0,32'h0,  32'h0,        10'd0, 0,0,0,32'h0,      3'b000,32'h0,        3'b000,32'h0,  32'h0,        0);
    v[13] = mk("rderr_push",    1,0,32'h400,32'h0,        10'd1, 0,0,0,32'h0,      3'b000,32'h0,        3'b000,32'h0,  32'h0,        0);
    v[14] = mk("rderr_slv",     1,0,32'h400,32'h0,        10'd1, 0,0,1,32'h55,     3'b000,32'h0,        3'b110,32'h400,32'h0,        0);
    v[15] = mk("rderr_resp",    1,0,32'h400,32'h0,        10'd1, 0,0,0,32'h0,      3'b111,32'h0,        3'b000,32'h0,  32'h0,        0);
    v[16] = mk("rderr_idle",    0,0,32'h0,  32'h0,        10'd0, 0,0,0,32'h0,      3'b000,32'h0,        3'b000,32'h0,  32'h0,        0);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step(v[i].mc, v[i].mw, v[i].adr, v[i].dat, v[i].bl, v[i].sa, v[i].sl, v[i].se, v[i].sd);
      chk(v[i].nm, outs(), v[i].exp);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 32'h1000 + 32'(4*i), 32'hC000_0000 + 32'(i), 10'd4, 0, 0, 0, 0);
      chk("burst_wr_ack", {m_if.ack, m_if.lack}, {1'b1, i == 3});
    end
    step(1, 1, 32'h2000, 32'h0, 10'd1, 0, 0, 0, 0);
    chk("burst_full_stall", {m_if.ack, s_if.stb, s_if.adr}, {1'b0, 1'b1, 32'h1000});
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1, i == 3, 0, 0);
      chk("burst_drain", {s_if.stb, s_if.we, s_if.adr, s_if.dat_w},
          {1'b1, 1'b1, 32'h1000 + 32'(4*i), 32'hC000_0000 + 32'(i)});
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("burst_empty", {s_if.cyc, m_if.ack}, 2'b00);
    k = 0; got = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      step(c == 0 || c >= 11, 0, 32'h500, 32'h0, 10'd8, 1, k == 7, 0, 32'hB000_0000 + 32'(k));
      if (c == 10) chk("rd8_throttle", {28'(k), s_if.cyc, s_if.stb}, {28'd7, 1'b1, 1'b0});
      if (s_if.stb) k++;
      if (m_if.ack) begin
        chk("rd8_beat", {m_if.lack, m_if.err, m_if.dat_r}, {got == 7, 1'b0, 32'hB000_0000 + 32'(got)});
        got++;
      end
    end
    chk("rd8_counts", {32'(got), 32'(k)}, {32'd8, 32'd8});
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rd8_idle", outs(), '0);
    step(1, 0, 32'h600, 32'h0, 10'd4, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 32'h6666_0000);
    step(0, 0, 0, 0, 0, 1, 0, 0, 32'h6666_0001);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("midrst_outs", outs(), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_release", outs(), '0);
    step(1, 1, 32'h700, 32'h7777_0007, 10'd1, 0, 0, 0, 0);
    chk("midrst_wr_ack", {m_if.ack, m_if.lack, s_if.cyc}, 3'b110);
    step(0, 0, 0, 0, 0, 1, 1, 0, 0);
    chk("midrst_wr_slv", {s_if.cyc, s_if.stb, s_if.we, s_if.adr, s_if.dat_w},
        {3'b111, 32'h700, 32'h7777_0007});
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("midrst_idle", outs(), '0);
`ifdef YCR1_WBB_TIMEOUT_EN
    n = 0; got = 0;
    for (int c = 0; c < 40 && got == 0; c++) begin
      step(1, 0, 32'h800, 32'h0, 10'd1, 0, 0, 0, 32'hFFFF_FFFF);
      if (s_if.stb) n++;
      if (m_if.ack) begin
        chk("to_resp", {m_if.lack, m_if.err, m_if.dat_r, bus_err, 32'(n)},
            {1'b1, 1'b1, 32'h0, 1'b1, 32'd16});
        got = 1;
      end
    end
    if (got == 0) chk("to_no_resp", 1'b0, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("to_idle", outs(), '0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
